// File: rtl/tx_iq_scale_pkg.sv
// Shared constants and FSM state type for the TX IQ amplitude scaling controller.
package tx_iq_scale_pkg;

    localparam logic [1:0] SEG_STF  = 2'd0;
    localparam logic [1:0] SEG_LTF  = 2'd1;
    localparam logic [1:0] SEG_SIG  = 2'd2;
    localparam logic [1:0] SEG_DATA = 2'd3;

    // The code-to-shift mapping is deliberately not monotonic.
    localparam logic [1:0] SC_X1   = 2'b00;
    localparam logic [1:0] SC_DIV8 = 2'b01;
    localparam logic [1:0] SC_DIV2 = 2'b10;
    localparam logic [1:0] SC_DIV4 = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/tx_iq_scale_lane.sv
// One combinational scaling lane: arithmetic right shift selected by a 2-bit code.
// TX_IQ_SCALE_ROUND_EN selects round-half-up instead of truncation toward -inf.
module tx_iq_scale_lane
    import tx_iq_scale_pkg::*;
#(
    parameter int IQ_W = 16
) (
    input  logic [IQ_W-1:0] i_x,
    input  logic [1:0]      i_code,
    output logic [IQ_W-1:0] o_y
);

    logic [IQ_W-1:0] w_d2;
    logic [IQ_W-1:0] w_d4;
    logic [IQ_W-1:0] w_d8;

`ifdef TX_IQ_SCALE_ROUND_EN
    // One extra bit of headroom, so adding the rounding constant cannot wrap.
    logic signed [IQ_W:0] w_ext;
    assign w_ext = $signed({i_x[IQ_W-1], i_x});
    assign w_d2  = IQ_W'((w_ext + $signed((IQ_W+1)'(1))) >>> 1);
    assign w_d4  = IQ_W'((w_ext + $signed((IQ_W+1)'(2))) >>> 2);
    assign w_d8  = IQ_W'((w_ext + $signed((IQ_W+1)'(4))) >>> 3);
`else
    assign w_d2 = IQ_W'($signed(i_x) >>> 1);
    assign w_d4 = IQ_W'($signed(i_x) >>> 2);
    assign w_d8 = IQ_W'($signed(i_x) >>> 3);
`endif

    always_comb begin
        case (i_code)
            SC_DIV8: o_y = w_d8;
            SC_DIV2: o_y = w_d2;
            SC_DIV4: o_y = w_d4;
            default: o_y = i_x;
        endcase
    end

endmodule

// File: rtl/tx_iq_scale_ctrl.sv
// Per-packet IQ scaling controller: segment-selected shift codes, double-buffered config,
// valid/ready stream with one registered output stage. Option: TX_IQ_SCALE_ROUND_EN.
module tx_iq_scale_ctrl
    import tx_iq_scale_pkg::*;
#(
    parameter int IQ_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IQ_W-1:0]  in_i,
    input  logic [IQ_W-1:0]  in_q,
    input  logic [1:0]       in_seg,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IQ_W-1:0]  out_i,
    output logic [IQ_W-1:0]  out_q,
    output logic             out_sop,
    output logic             out_eop,
    input  logic [7:0]       cfg_shift,
    input  logic             cfg_load,
    output logic             busy,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             err_sticky
);

    state_t           r_state, w_state_nxt;
    logic [7:0]       r_shadow;
    logic [7:0]       r_active, w_active_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_err, w_err_nxt;
    logic             r_out_valid;
    logic [IQ_W-1:0]  r_out_i, r_out_q;
    logic             r_out_sop, r_out_eop;

    logic             w_accept;
    logic             w_accept_sop;
    logic [7:0]       w_sop_codes;
    logic [7:0]       w_codes;
    logic [1:0]       w_code;
    logic [IQ_W-1:0]  w_scaled_i, w_scaled_q;

    assign in_ready     = !r_out_valid || out_ready;
    assign w_accept     = in_valid && in_ready;
    assign w_accept_sop = w_accept && in_sop;

    // A config strobe coinciding with sop bypasses the shadow and lands in the new packet.
    assign w_sop_codes = cfg_load ? cfg_shift : r_shadow;
    assign w_codes     = w_accept_sop ? w_sop_codes : r_active;

    always_comb begin
        case (in_seg)
            SEG_STF: w_code = w_codes[1:0];
            SEG_LTF: w_code = w_codes[3:2];
            SEG_SIG: w_code = w_codes[5:4];
            default: w_code = w_codes[7:6];
        endcase
    end

    tx_iq_scale_lane #(.IQ_W(IQ_W)) u_lane_i (
        .i_x    (in_i),
        .i_code (w_code),
        .o_y    (w_scaled_i)
    );

    tx_iq_scale_lane #(.IQ_W(IQ_W)) u_lane_q (
        .i_x    (in_q),
        .i_code (w_code),
        .o_y    (w_scaled_q)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_cnt_nxt    = r_cnt;
        w_err_nxt    = r_err;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_sop) begin
                        w_active_nxt = w_sop_codes;
                        w_cnt_nxt    = CNT_W'(1);
                        w_state_nxt  = in_eop ? ST_IDLE : ST_ACTIVE;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_accept) begin
                    if (in_sop) begin
                        w_err_nxt    = 1'b1;
                        w_active_nxt = w_sop_codes;
                        w_cnt_nxt    = CNT_W'(1);
                    end else if (r_cnt != {CNT_W{1'b1}}) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    if (in_eop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_shadow <= 8'h00;
            r_active <= 8'h00;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_cnt    <= w_cnt_nxt;
            r_err    <= w_err_nxt;
            if (cfg_load) begin
                r_shadow <= cfg_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_i     <= '0;
            r_out_q     <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
        end else if (in_ready) begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_i   <= w_scaled_i;
                r_out_q   <= w_scaled_q;
                r_out_sop <= in_sop;
                r_out_eop <= in_eop;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_i      = r_out_i;
    assign out_q      = r_out_q;
    assign out_sop    = r_out_sop;
    assign out_eop    = r_out_eop;
    assign busy       = (r_state == ST_ACTIVE);
    assign pkt_cnt    = r_cnt;
    assign err_sticky = r_err;

endmodule

// File: tb/tb_tx_iq_scale_ctrl.sv
// Scoreboard bench for tx_iq_scale_ctrl: directed packets push expected samples,
// a negedge monitor pops and compares each transferred output.
module tb_tx_iq_scale_ctrl;

    localparam int IQ_W  = 16;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [IQ_W-1:0]  in_i, in_q;
    logic [1:0]       in_seg;
    logic             in_sop, in_eop;
    logic             out_valid;
    logic             out_ready;
    logic [IQ_W-1:0]  out_i, out_q;
    logic             out_sop, out_eop;
    logic [7:0]       cfg_shift;
    logic             cfg_load;
    logic             busy;
    logic [CNT_W-1:0] pkt_cnt;
    logic             err_sticky;

    tx_iq_scale_ctrl #(.IQ_W(IQ_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_i       (in_i),
        .in_q       (in_q),
        .in_seg     (in_seg),
        .in_sop     (in_sop),
        .in_eop     (in_eop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .cfg_shift  (cfg_shift),
        .cfg_load   (cfg_load),
        .busy       (busy),
        .pkt_cnt    (pkt_cnt),
        .err_sticky (err_sticky)
    );

`ifdef TX_IQ_SCALE_ROUND_EN
    localparam logic [15:0] R_I0 = 16'h0002;
    localparam logic [15:0] R_Q0 = 16'hFFFF;
    localparam logic [15:0] R_I1 = 16'h1000;
`else
    localparam logic [15:0] R_I0 = 16'h0001;
    localparam logic [15:0] R_Q0 = 16'hFFFE;
    localparam logic [15:0] R_I1 = 16'h0FFF;
`endif

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        sop;
        logic        eop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   bp_en  = 1'b0;
    bit   rdy_val = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready, updated 2 time units after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: pops one expectation per transfer and checks hold stability under backpressure.
    initial begin : monitor
        exp_t        e;
        logic        stalled;
        logic [15:0] h_i, h_q;
        logic        h_sop, h_eop;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sb.delete();
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_i", 32'(out_i), 32'(h_i));
                    check("hold_q", 32'(out_q), 32'(h_q));
                    check("hold_flags", {30'd0, out_sop, out_eop}, {30'd0, h_sop, h_eop});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got i=%h q=%h expected no sample", out_i, out_q);
                    end else begin
                        e = sb.pop_front();
                        check("out_i", 32'(out_i), 32'(e.i));
                        check("out_q", 32'(out_q), 32'(e.q));
                        check("out_sop", 32'(out_sop), 32'(e.sop));
                        check("out_eop", 32'(out_eop), 32'(e.eop));
                    end
                end
                stalled = out_valid && !out_ready;
                h_i = out_i;
                h_q = out_q;
                h_sop = out_sop;
                h_eop = out_eop;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the sample is accepted, in_valid left high.
    task automatic send(input logic [15:0] i, input logic [15:0] q, input logic [1:0] seg,
                        input logic sop, input logic eop, input logic [15:0] ei, input logic [15:0] eq);
        exp_t e;
        int   n;
        e.i = ei;
        e.q = eq;
        e.sop = sop;
        e.eop = eop;
        sb.push_back(e);
        in_i = i;
        in_q = q;
        in_seg = seg;
        in_sop = sop;
        in_eop = eop;
        in_valid = 1'b1;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready || n >= 200) break;
            n++;
        end
        @(posedge clk);
        #1;
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 200 cycles");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
    endtask

    task automatic load_cfg(input logic [7:0] v);
        cfg_shift = v;
        cfg_load = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        time t0;
        rstn = 1'b0;
        in_valid = 1'b0;
        in_i = '0;
        in_q = '0;
        in_seg = 2'd0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        cfg_shift = 8'h00;
        cfg_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_i", 32'(out_i), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_err", 32'(err_sticky), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic per-segment scaling
        load_cfg(8'b11_10_01_00);
        send(16'h4000, 16'hC000, 2'd0, 1'b1, 1'b0, 16'h4000, 16'hC000);
        check("t1_busy_after_sop", 32'(busy), 32'd1);
        check("t1_cnt_after_sop", 32'(pkt_cnt), 32'd1);
        send(16'h4000, 16'hC000, 2'd1, 1'b0, 1'b0, 16'h0800, 16'hF800);
        send(16'h4000, 16'hC000, 2'd2, 1'b0, 1'b0, 16'h2000, 16'hE000);
        send(16'h4000, 16'hC000, 2'd3, 1'b0, 1'b1, 16'h1000, 16'hF000);
        idle();
        drain();
        check("t1_pkt_cnt", 32'(pkt_cnt), 32'd4);
        check("t1_busy_idle", 32'(busy), 32'd0);
        check("t1_err", 32'(err_sticky), 32'd0);

        // Mid-packet config load waits for the next sop
        send(16'h4000, 16'hC000, 2'd0, 1'b1, 1'b0, 16'h4000, 16'hC000);
        cfg_shift = 8'h01;
        cfg_load = 1'b1;
        send(16'h4000, 16'hC000, 2'd0, 1'b0, 1'b0, 16'h4000, 16'hC000);
        cfg_load = 1'b0;
        send(16'h4000, 16'hC000, 2'd1, 1'b0, 1'b1, 16'h0800, 16'hF800);
        idle();
        send(16'h4000, 16'hC000, 2'd0, 1'b1, 1'b1, 16'h0800, 16'hF800);
        idle();
        drain();
        check("t2_single_busy", 32'(busy), 32'd0);
        check("t2_single_cnt", 32'(pkt_cnt), 32'd1);
        // Config strobe in the sop cycle applies immediately
        cfg_shift = 8'h02;
        cfg_load = 1'b1;
        send(16'h4000, 16'hC000, 2'd0, 1'b1, 1'b0, 16'h2000, 16'hE000);
        cfg_load = 1'b0;
        send(16'h4000, 16'hC000, 2'd0, 1'b0, 1'b1, 16'h2000, 16'hE000);
        idle();
        drain();
        check("t2_cnt", 32'(pkt_cnt), 32'd2);

        // Random backpressure with unity codes: output must equal input, in order
        load_cfg(8'h00);
        bp_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            send(16'h0100 + 16'(k), 16'hFF00 - 16'(k), 2'(k), (k == 0), (k == 15),
                 16'h0100 + 16'(k), 16'hFF00 - 16'(k));
        end
        idle();
        drain();
        bp_en = 1'b0;
        check("t3_pkt_cnt", 32'(pkt_cnt), 32'd16);
        check("t3_busy", 32'(busy), 32'd0);

        // Full throughput with out_ready held high
        repeat (2) @(posedge clk);
        #1;
        t0 = $time;
        for (int k = 0; k < 8; k++) begin
            send(16'h1230 + 16'(k), 16'h4560 + 16'(k), 2'd3, (k == 0), (k == 7),
                 16'h1230 + 16'(k), 16'h4560 + 16'(k));
        end
        check("t4_throughput_time", 32'($time - t0), 32'd80);
        idle();
        drain();
        check("t4_pkt_cnt", 32'(pkt_cnt), 32'd8);

        // Protocol error: sample without sop in IDLE
        do_reset();
        send(16'h1234, 16'h5678, 2'd2, 1'b0, 1'b0, 16'h1234, 16'h5678);
        idle();
        drain();
        check("t5_nosop_err", 32'(err_sticky), 32'd1);
        check("t5_nosop_cnt", 32'(pkt_cnt), 32'd0);
        check("t5_nosop_busy", 32'(busy), 32'd0);
        // Protocol error: double sop restarts the count
        do_reset();
        check("t5_err_cleared", 32'(err_sticky), 32'd0);
        send(16'h1111, 16'h2222, 2'd0, 1'b1, 1'b0, 16'h1111, 16'h2222);
        send(16'h3333, 16'h4444, 2'd0, 1'b0, 1'b0, 16'h3333, 16'h4444);
        check("t5_cnt_before_dsop", 32'(pkt_cnt), 32'd2);
        send(16'h5555, 16'h6666, 2'd0, 1'b1, 1'b0, 16'h5555, 16'h6666);
        check("t5_dsop_err", 32'(err_sticky), 32'd1);
        check("t5_dsop_cnt", 32'(pkt_cnt), 32'd1);
        check("t5_dsop_busy", 32'(busy), 32'd1);
        send(16'h7777, 16'h8888, 2'd0, 1'b0, 1'b1, 16'h7777, 16'h8888);
        idle();
        drain();
        check("t5_final_cnt", 32'(pkt_cnt), 32'd2);
        check("t5_final_busy", 32'(busy), 32'd0);

        // Rounding vs truncation
        load_cfg(8'h06);
        send(16'h0003, 16'hFFFD, 2'd0, 1'b1, 1'b0, R_I0, R_Q0);
        send(16'h7FFF, 16'h8000, 2'd1, 1'b0, 1'b1, R_I1, 16'hF000);
        idle();
        drain();

        // Reset mid-packet with an output stalled
        load_cfg(8'hFF);
        rdy_val = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        send(16'h4000, 16'hC000, 2'd0, 1'b1, 1'b0, 16'h1000, 16'hF000);
        idle();
        check("t7_stalled_valid", 32'(out_valid), 32'd1);
        check("t7_busy_before", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("t7_valid_drop", 32'(out_valid), 32'd0);
        check("t7_busy_drop", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rdy_val = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("t7_post_busy", 32'(busy), 32'd0);
        check("t7_post_cnt", 32'(pkt_cnt), 32'd0);
        check("t7_post_err", 32'(err_sticky), 32'd0);
        send(16'h4000, 16'hC000, 2'd0, 1'b1, 1'b1, 16'h4000, 16'hC000);
        idle();
        drain();
        check("t7_unity_cnt", 32'(pkt_cnt), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
